// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared state encoding and default widths for the MAC accumulator
package mac_pkg;

   localparam int ACC_W_DEF = 12;
   localparam int LEN_W_DEF = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } mac_state_t;

endpackage

// File: rtl/mac_ctrl.sv
// rtl/mac_ctrl.sv - burst FSM, remaining-pair counter and registered handshake outputs
module mac_ctrl
   import mac_pkg::*;
#(
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic [LEN_W-1:0] i_len,
   input  logic             i_in_valid,
   input  logic             i_out_ready,
   output logic             o_in_ready,
   output logic             o_out_valid,
   output logic             o_accept,
   output logic             o_clear
);

   mac_state_t       r_state;
   logic [LEN_W-1:0] r_remaining;
   logic             r_in_ready;
   logic             r_out_valid;
   logic             w_accept;
   logic             w_clear;

   // in_ready is only ever high in RUN, so a handshake needs no state decode
   assign w_accept = i_in_valid && r_in_ready;
   // a start outside IDLE is ignored, so clearing the datapath is gated on IDLE
   assign w_clear  = i_start && (r_state == S_IDLE);

   assign o_in_ready  = r_in_ready;
   assign o_out_valid = r_out_valid;
   assign o_accept    = w_accept;
   assign o_clear     = w_clear;

   // state transitions; handshake outputs are registered alongside the next state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_remaining <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  if (i_len != '0) begin
                     r_state     <= S_RUN;
                     r_remaining <= i_len;
                     r_in_ready  <= 1'b1;
                  end else begin
                     r_state     <= S_DONE;
                     r_out_valid <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (w_accept) begin
                  r_remaining <= r_remaining - LEN_W'(1);
                  if (r_remaining == LEN_W'(1)) begin
                     r_state    <= S_DRAIN;
                     r_in_ready <= 1'b0;
                  end
               end
            end
            S_DRAIN: begin
               // the last product retires on this edge in the datapath
               r_state     <= S_DONE;
               r_out_valid <= 1'b1;
            end
            S_DONE: begin
               if (i_out_ready) begin
                  r_state     <= S_IDLE;
                  r_out_valid <= 1'b0;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_in_ready  <= 1'b0;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - multiply-accumulate controller around an external 4x4 multiplier
module mac_accumulator
   import mac_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       a,
   input  logic [3:0]       b,
   output logic [3:0]       mult_a,
   output logic [3:0]       mult_b,
   input  logic [7:0]       mult_p,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] acc,
   output logic             overflow
);

   logic             w_accept;
   logic             w_clear;
   logic [ACC_W:0]   w_sum;
   logic [3:0]       r_mult_a;
   logic [3:0]       r_mult_b;
   logic             r_pend;
   logic [ACC_W-1:0] r_acc;
   logic             r_overflow;

   mac_ctrl #(
      .LEN_W (LEN_W)
   ) u_ctrl (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_start     (start),
      .i_len       (len),
      .i_in_valid  (in_valid),
      .i_out_ready (out_ready),
      .o_in_ready  (in_ready),
      .o_out_valid (out_valid),
      .o_accept    (w_accept),
      .o_clear     (w_clear)
   );

   // one extra bit so the carry-out can be observed for the sticky overflow flag
   assign w_sum = {1'b0, r_acc} + {{(ACC_W - 7){1'b0}}, mult_p};

   // operand capture, pending-product tracking and accumulation
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mult_a   <= 4'd0;
         r_mult_b   <= 4'd0;
         r_pend     <= 1'b0;
         r_acc      <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_clear) begin
            r_acc      <= '0;
            r_overflow <= 1'b0;
            r_pend     <= 1'b0;
         end else begin
            if (r_pend) begin
               r_acc <= w_sum[ACC_W-1:0];
               if (w_sum[ACC_W]) begin
                  r_overflow <= 1'b1;
               end
            end
            if (w_accept) begin
               r_mult_a <= a;
               r_mult_b <= b;
               r_pend   <= 1'b1;
            end else begin
               r_pend   <= 1'b0;
            end
         end
      end
   end

   assign mult_a   = r_mult_a;
   assign mult_b   = r_mult_b;
   assign acc      = r_acc;
   assign overflow = r_overflow;

endmodule

// File: tb/tb_mac_accumulator.sv
// tb/tb_mac_accumulator.sv - directed self-checking bench for mac_accumulator
module tb_mac_accumulator;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [3:0]  len;
   logic        in_valid;
   logic [3:0]  a;
   logic [3:0]  b;
   logic        out_ready;

   logic        ir12, ov12, of12;
   logic [3:0]  ma12, mb12;
   logic [7:0]  p12;
   logic [11:0] acc12;

   logic        ir8, ov8, of8;
   logic [3:0]  ma8, mb8;
   logic [7:0]  p8;
   logic [7:0]  acc8;

   int n_checks = 0;
   int n_fail   = 0;

   // the 4x4 array multiplier sitting between mult_a/mult_b and mult_p
   assign p12 = {4'd0, ma12} * {4'd0, mb12};
   assign p8  = {4'd0, ma8}  * {4'd0, mb8};

   mac_accumulator #(.ACC_W(12), .LEN_W(4)) dut12 (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len),
      .in_valid(in_valid), .in_ready(ir12), .a(a), .b(b),
      .mult_a(ma12), .mult_b(mb12), .mult_p(p12),
      .out_valid(ov12), .out_ready(out_ready), .acc(acc12), .overflow(of12)
   );

   mac_accumulator #(.ACC_W(8), .LEN_W(4)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len),
      .in_valid(in_valid), .in_ready(ir8), .a(a), .b(b),
      .mult_a(ma8), .mult_b(mb8), .mult_p(p8),
      .out_valid(ov8), .out_ready(out_ready), .acc(acc8), .overflow(of8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      int accepted;
      int k;

      // reset with random inputs
      rst_n = 1'b0;
      start = 1'($urandom); len = 4'($urandom); in_valid = 1'($urandom);
      a = 4'($urandom); b = 4'($urandom); out_ready = 1'($urandom);
      step();
      start = 1'($urandom); in_valid = 1'($urandom); a = 4'($urandom); b = 4'($urandom);
      step();
      chk("rst_in_ready",  ir12, 0);
      chk("rst_out_valid", ov12, 0);
      chk("rst_acc",       acc12, 0);
      chk("rst_overflow",  of12, 0);
      chk("rst_mult_a",    ma12, 0);
      chk("rst_mult_b",    mb12, 0);
      chk("rst_in_ready8", ir8, 0);
      chk("rst_acc8",      acc8, 0);

      rst_n = 1'b1; start = 1'b0; len = 4'd0; in_valid = 1'b0;
      a = 4'd0; b = 4'd0; out_ready = 1'b0;
      step();
      chk("idle_in_ready", ir12, 0);

      // basic burst: len=3, (3,5),(15,15),(2,7) -> 254
      start = 1'b1; len = 4'd3;
      step();
      start = 1'b0;
      chk("basic_run_ready", ir12, 1);
      in_valid = 1'b1; a = 4'd3; b = 4'd5;
      step();
      chk("basic_mult_a", ma12, 3);
      chk("basic_mult_b", mb12, 5);
      a = 4'd15; b = 4'd15;
      step();
      chk("basic_acc_partial", acc12, 15);
      a = 4'd2; b = 4'd7;
      step();
      in_valid = 1'b0;
      chk("basic_drain_ready", ir12, 0);
      chk("basic_drain_valid", ov12, 0);
      step();
      chk("basic_out_valid", ov12, 1);
      chk("basic_acc",       acc12, 254);
      chk("basic_overflow",  of12, 0);
      chk("basic_acc8",      acc8, 254);
      step();
      chk("basic_hold_valid", ov12, 1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("basic_idle_valid", ov12, 0);
      chk("basic_idle_acc",   acc12, 254);

      // overflow on the 8-bit instance: len=2, (15,15)x2 -> 194 with carry
      start = 1'b1; len = 4'd2;
      step();
      start = 1'b0;
      in_valid = 1'b1; a = 4'd15; b = 4'd15;
      step();
      step();
      in_valid = 1'b0;
      step();
      chk("ovf_out_valid8", ov8, 1);
      chk("ovf_acc8",       acc8, 194);
      chk("ovf_flag8",      of8, 1);
      chk("ovf_acc12",      acc12, 450);
      chk("ovf_flag12",     of12, 0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("ovf_idle_flag8", of8, 1);

      // zero length start: result next cycle, clears overflow
      start = 1'b1; len = 4'd0;
      step();
      start = 1'b0;
      chk("zero_out_valid", ov12, 1);
      chk("zero_acc",       acc12, 0);
      chk("zero_flag8",     of8, 0);
      chk("zero_in_ready",  ir12, 0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // start pulsed during RUN is ignored: len=2, (1,2),(3,4) -> 14
      start = 1'b1; len = 4'd2;
      step();
      start = 1'b1; len = 4'd5;
      in_valid = 1'b1; a = 4'd1; b = 4'd2;
      step();
      start = 1'b0;
      a = 4'd3; b = 4'd4;
      step();
      in_valid = 1'b0;
      step();
      chk("ign_out_valid", ov12, 1);
      chk("ign_acc",       acc12, 14);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // stalls and backpressure: len=15, (15,15) each -> 3375
      start = 1'b1; len = 4'd15;
      step();
      start = 1'b0;
      a = 4'd15; b = 4'd15;
      accepted = 0;
      for (int c = 0; c < 200 && accepted < 15; c++) begin
         in_valid = 1'($urandom_range(0, 1));
         if (in_valid && ir12) accepted++;
         step();
      end
      in_valid = 1'b0;
      chk("stall_all_accepted", accepted, 15);
      k = 0;
      while (!ov12 && k < 20) begin
         step();
         k++;
      end
      chk("stall_out_valid", ov12, 1);
      chk("stall_acc",       acc12, 3375);
      chk("stall_overflow",  of12, 0);
      chk("stall_acc8",      acc8, 47);
      chk("stall_flag8",     of8, 1);
      for (int c = 0; c < 5; c++) begin
         step();
         chk("bp_out_valid", ov12, 1);
         chk("bp_acc",       acc12, 3375);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("bp_released", ov12, 0);

      // reset mid-burst: len=4, two pairs, then reset
      start = 1'b1; len = 4'd4;
      step();
      start = 1'b0;
      in_valid = 1'b1; a = 4'd5; b = 4'd5;
      step();
      a = 4'd6; b = 4'd6;
      step();
      in_valid = 1'b0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("mid_rst_acc",       acc12, 0);
      chk("mid_rst_in_ready",  ir12, 0);
      chk("mid_rst_out_valid", ov12, 0);
      chk("mid_rst_mult_a",    ma12, 0);
      step();
      chk("mid_rst_acc_hold",  acc12, 0);

      // new burst len=1 with (4,4) -> 16
      start = 1'b1; len = 4'd1;
      step();
      start = 1'b0;
      in_valid = 1'b1; a = 4'd4; b = 4'd4;
      step();
      in_valid = 1'b0;
      chk("post_rst_drain_ready", ir12, 0);
      step();
      chk("post_rst_out_valid", ov12, 1);
      chk("post_rst_acc",       acc12, 16);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Sequential multiply-accumulate controller sitting directly downstream of the team's 4x4 combinational array multiplier. Accepts a burst of `len` operand pairs over a valid/ready handshake, registers each pair onto the multiplier inputs, and folds each 8-bit product into a running sum. Presents the final dot product on a valid/ready result port.

## Interface
Parameters:
- `ACC_W`, default 12: accumulator width; must be ≥ 8.
- `LEN_W`, default 4: width of burst length; maximum burst is 2^LEN_W − 1.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  begin a burst; sampled only in IDLE.
- `len`  in  LEN_W  number of operand pairs in the burst; sampled with `start`.
- `in_valid`  in  1  operand pair on `a`/`b` is valid.
- `in_ready`  out  1  block accepts an operand pair this cycle.
- `a`  in  4  multiplicand.
- `b`  in  4  multiplier.
- `mult_a`  out  4  registered operand to the external multiplier's `a`.
- `mult_b`  out  4  registered operand to the external multiplier's `b`.
- `mult_p`  in  8  combinational product returned by the multiplier.
- `out_valid`  out  1  `acc` holds the final burst result.
- `out_ready`  in  1  consumer takes the result.
- `acc`  out  ACC_W  running or final sum.
- `overflow`  out  1  sticky; set when any accumulate carries out of ACC_W.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: `start`=1 and `len`≠0 → clear `acc`, clear `overflow`, load `remaining`=`len`, go to RUN. `start`=1 and `len`=0 → clear `acc`/`overflow`, go directly to DONE. `start` is ignored in every state other than IDLE.
- RUN: `in_ready`=1. On `in_valid && in_ready`: latch `a`→`mult_a`, `b`→`mult_b`, set `pend`, decrement `remaining`. When the last pair is accepted (`remaining`=1), go to DRAIN.
- Accumulate: on any edge where `pend`=1, `acc` ← `acc` + zero-extended `mult_p`, then clear `pend` unless a new pair is accepted on the same edge. Back-to-back acceptance is allowed at full rate, one pair per cycle.
- Arithmetic: sum is ACC_W+1 bits; `acc` takes the low ACC_W bits, wrapping. A carry-out sets `overflow`, which stays set until the next `start`.
- DRAIN: `in_ready`=0; perform the final accumulate, then go to DONE.
- DONE: `out_valid`=1 and `acc` is stable. `out_ready`=1 → IDLE. `acc` and `overflow` hold their values in IDLE until the next `start`.

## Timing
- Reset, taking priority over everything: state=IDLE; `in_ready`=0; `out_valid`=0; `acc`=0; `overflow`=0; `mult_a`=`mult_b`=0; `pend`=0; `remaining`=0.
- A reset asserted mid-burst aborts the burst. Any pending product is discarded.
- `in_ready` and `out_valid` are pure functions of the registered state (Moore outputs). There is no combinational path from `in_valid` or `out_ready` to them.
- Pair accepted on edge k → contributes to `acc` on edge k+1.
- Latency: `start` on edge 0 → RUN on cycle 1. With zero stall, the last pair is accepted at edge `len` and DONE is reached at edge `len`+1, with `out_valid` high from cycle `len`+1.
- `len`=0: `out_valid` is high in the cycle following `start`.
- `in_valid` deasserted in RUN stalls the burst. `pend` still retires normally.
- `out_ready` held low keeps DONE indefinitely with `acc` unchanged.

## Structure
- Package `mac_pkg`: state enum (IDLE, RUN, DRAIN, DONE) and the default localparams for ACC_W and LEN_W.
- The multiplier stays external and connects via `mult_a`/`mult_b`/`mult_p`. The bench instantiates the team's array multiplier between these ports.
- One natural sub-module: `mac_ctrl`, which holds the FSM, `remaining` counter and handshake outputs. The datapath (operand registers, accumulator, overflow) stays in the top level.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with random inputs → all outputs 0, state IDLE.
- Basic burst: `len`=3, pairs (3,5),(15,15),(2,7) presented without stalls → `out_valid` at cycle 4, `acc`=15+225+14=254, `overflow`=0. `out_ready`=1 → back to IDLE.
- Stalls and backpressure: `len`=15, all pairs (15,15), `in_valid` toggled randomly, `out_ready` held low 5 cycles → `acc`=3375, result held stable until `out_ready`.
- Overflow: ACC_W=8, `len`=2, pairs (15,15),(15,15) → `acc`=450 mod 256=194, `overflow`=1. A following `start` clears `overflow` to 0.
- Zero length and ignored start: `len`=0 `start` → `out_valid` next cycle with `acc`=0. A `start` pulsed during RUN of a `len`=2 burst has no effect.
- Reset mid-burst: `len`=4, apply reset after 2 pairs accepted → IDLE, `acc`=0. A new `len`=1 burst with (4,4) gives `acc`=16.
